alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mul_seq.sv | 49 ++++
 rtl/alu_pipe.sv | 108 ++++++++++
 tb/tb_alu_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and flag bit positions shared by the ALU pipe
package alu_pkg;

   localparam logic [3:0] OP_ADD_BA = 4'd0;
   localparam logic [3:0] OP_SUB_BA = 4'd1;
   localparam logic [3:0] OP_GT     = 4'd2;
   localparam logic [3:0] OP_AND_BA = 4'd3;
   localparam logic [3:0] OP_OR_BA  = 4'd4;
   localparam logic [3:0] OP_XOR_BA = 4'd5;
   localparam logic [3:0] OP_AND_AB = 4'd6;
   localparam logic [3:0] OP_OR_AB  = 4'd7;
   localparam logic [3:0] OP_XOR_AB = 4'd8;
   localparam logic [3:0] OP_ADD_AB = 4'd9;
   localparam logic [3:0] OP_SUB_AB = 4'd10;
   localparam logic [3:0] OP_SHL    = 4'd11;
   localparam logic [3:0] OP_SHR    = 4'd12;
   localparam logic [3:0] OP_SAR    = 4'd13;
   localparam logic [3:0] OP_MUL    = 4'd14;
   localparam logic [3:0] OP_ZERO   = 4'd15;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int NFLAGS   = 3;
   localparam int FLAG_NEG  = 0;
   localparam int FLAG_ZERO = 1;
   localparam int FLAG_OVF  = 2;
   // a cleared result reads as zero, so the zero flag is set out of reset
   localparam logic [NFLAGS-1:0] FLAGS_RESET = 3'b010;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier, one partial product per cycle
module alu_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic               busy;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   // product includes the step taken this cycle, so the final step and the
   // caller's result capture share the same edge
   assign product = acc + (mplier[0] ? mcand : '0);
   assign done    = busy && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU: single-cycle ops plus an iterative multiply, registered result and flags
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       codop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             neg,
   output logic             zero,
   output logic             overflow
);

   logic [1:0]         state;
   logic [WIDTH-1:0]   out_r;
   logic [NFLAGS-1:0]  flags_r;
   logic               accept;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf;
   logic [WIDTH:0]     sum;
   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   nxt_res;
   logic               nxt_ovf;
   logic [NFLAGS-1:0]  nxt_flags;

   assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign shamt     = b[SHW-1:0];
   assign sum       = {1'b0, a} + {1'b0, b};

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && (codop == OP_MUL)),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (codop)
         OP_ADD_BA, OP_ADD_AB: begin alu_res = sum[WIDTH-1:0]; alu_ovf = sum[WIDTH]; end
         OP_SUB_BA: begin alu_res = b - a; alu_ovf = (a > b); end
         OP_SUB_AB: begin alu_res = a - b; alu_ovf = (a < b); end
         OP_GT:     alu_res = (a > b) ? WIDTH'(1) : '0;
         OP_AND_BA, OP_AND_AB: alu_res = a & b;
         OP_OR_BA,  OP_OR_AB:  alu_res = a | b;
         OP_XOR_BA, OP_XOR_AB: alu_res = a ^ b;
         OP_SHL:    alu_res = a << shamt;
         OP_SHR:    alu_res = a >> shamt;
         OP_SAR:    alu_res = $signed(a) >>> shamt;
         default:   alu_res = '0;
      endcase
   end

   // in MUL the only writer of the result is the multiplier; otherwise the single-cycle path
   always_comb begin
      nxt_res   = (state == ST_MUL) ? mul_prod[WIDTH-1:0] : alu_res;
      nxt_ovf   = (state == ST_MUL) ? (|mul_prod[2*WIDTH-1:WIDTH]) : alu_ovf;
      nxt_flags = '0;
      nxt_flags[FLAG_NEG]  = nxt_res[WIDTH-1];
      nxt_flags[FLAG_ZERO] = (nxt_res == '0);
      nxt_flags[FLAG_OVF]  = nxt_ovf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         out_r   <= '0;
         flags_r <= FLAGS_RESET;
      end else if (accept) begin
         if (codop == OP_MUL) begin
            state <= ST_MUL;
         end else begin
            state   <= ST_DONE;
            out_r   <= nxt_res;
            flags_r <= nxt_flags;
         end
      end else if ((state == ST_MUL) && mul_done) begin
         state   <= ST_DONE;
         out_r   <= nxt_res;
         flags_r <= nxt_flags;
      end else if ((state == ST_DONE) && out_ready) begin
         state <= ST_IDLE;
      end
   end

   assign out      = out_r;
   assign neg      = flags_r[FLAG_NEG];
   assign zero     = flags_r[FLAG_ZERO];
   assign overflow = flags_r[FLAG_OVF];

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe at WIDTH=16
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  codop;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] out;
   logic        out_valid;
   logic        out_ready;
   logic        neg;
   logic        zero;
   logic        overflow;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [2:0]  f;
   } vec_t;

   alu_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .codop     (codop),
      .a         (a),
      .b         (b),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .neg       (neg),
      .zero      (zero),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic do_issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
      in_valid = 1'b1;
      codop    = op;
      a        = x;
      b        = y;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; codop = 4'd0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got %h want 0000", out); end
      n_chk++; if ({neg, zero, overflow} !== 3'b010) begin n_fail++; $display("FAIL reset_flags got %b want 010", {neg, zero, overflow}); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      rst = 1'b0;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_add_overflow;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready got %b want 1", in_ready); end
      do_issue(4'd0, 16'hFFFF, 16'h0001);
      n_chk++; if (out !== 16'h0000) begin n_fail++; $display("FAIL add_out got %h want 0000", out); end
      n_chk++; if ({neg, zero, overflow} !== 3'b011) begin n_fail++; $display("FAIL add_flags got %b want 011", {neg, zero, overflow}); end
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid got %b want 1", out_valid); end
   endtask

   task automatic test_vectors;
      vec_t vt [0:18];
      vt[0]  = '{4'd13, 16'h8000, 16'h0013, 16'hF000, 3'b100};
      vt[1]  = '{4'd1,  16'h0005, 16'h0003, 16'hFFFE, 3'b101};
      vt[2]  = '{4'd2,  16'h0005, 16'h0003, 16'h0001, 3'b000};
      vt[3]  = '{4'd2,  16'h0003, 16'h0005, 16'h0000, 3'b010};
      vt[4]  = '{4'd3,  16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000};
      vt[5]  = '{4'd4,  16'hF0F0, 16'h0FF0, 16'hFFF0, 3'b100};
      vt[6]  = '{4'd5,  16'hF0F0, 16'h0FF0, 16'hFF00, 3'b100};
      vt[7]  = '{4'd6,  16'h00FF, 16'h0F0F, 16'h000F, 3'b000};
      vt[8]  = '{4'd7,  16'h00FF, 16'h0F0F, 16'h0FFF, 3'b000};
      vt[9]  = '{4'd8,  16'h00FF, 16'h0F0F, 16'h0FF0, 3'b000};
      vt[10] = '{4'd9,  16'h8000, 16'h8000, 16'h0000, 3'b011};
      vt[11] = '{4'd10, 16'h0003, 16'h0005, 16'hFFFE, 3'b101};
      vt[12] = '{4'd10, 16'h0005, 16'h0003, 16'h0002, 3'b000};
      vt[13] = '{4'd11, 16'h0001, 16'h0024, 16'h0010, 3'b000};
      vt[14] = '{4'd12, 16'h8000, 16'h00F4, 16'h0800, 3'b000};
      vt[15] = '{4'd15, 16'h1234, 16'h5678, 16'h0000, 3'b010};
      vt[16] = '{4'd0,  16'h1234, 16'h0001, 16'h1235, 3'b000};
      vt[17] = '{4'd1,  16'h0003, 16'h0003, 16'h0000, 3'b010};
      vt[18] = '{4'd13, 16'h4000, 16'h0011, 16'h2000, 3'b000};
      for (int i = 0; i < 19; i++) begin
         n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_in_ready got %b want 1", i, in_ready); end
         do_issue(vt[i].op, vt[i].a, vt[i].b);
         n_chk++; if (out !== vt[i].res) begin n_fail++; $display("FAIL vec%0d_out op %0d got %h want %h", i, vt[i].op, out, vt[i].res); end
         n_chk++; if ({neg, zero, overflow} !== vt[i].f) begin n_fail++; $display("FAIL vec%0d_flags op %0d got %b want %b", i, vt[i].op, {neg, zero, overflow}, vt[i].f); end
         n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_out_valid got %b want 1", i, out_valid); end
      end
   endtask

   task automatic test_mul(input logic [15:0] x, input logic [15:0] y, input logic [15:0] res, input logic [2:0] f);
      int cyc;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_in_ready_pre got %b want 1", in_ready); end
      do_issue(4'd14, x, y);
      // a competing request during MUL must be left pending
      in_valid = 1'b1; codop = 4'd0; a = 16'h0001; b = 16'h0001;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready_busy cycle %0d got %b want 0", cyc, in_ready); end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      n_chk++; if (cyc !== 16) begin n_fail++; $display("FAIL mul_latency %h*%h got %0d want 16", x, y, cyc); end
      n_chk++; if (out !== res) begin n_fail++; $display("FAIL mul_out %h*%h got %h want %h", x, y, out, res); end
      n_chk++; if ({neg, zero, overflow} !== f) begin n_fail++; $display("FAIL mul_flags %h*%h got %b want %b", x, y, {neg, zero, overflow}, f); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      do_issue(4'd7, 16'h00F0, 16'h0F00);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_chk++; if (out !== 16'h0FF0) begin n_fail++; $display("FAIL hold%0d_out got %h want 0ff0", i, out); end
         n_chk++; if ({neg, zero, overflow, out_valid} !== 4'b0001) begin n_fail++; $display("FAIL hold%0d_flags_valid got %b want 0001", i, {neg, zero, overflow, out_valid}); end
         n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold%0d_in_ready got %b want 0", i, in_ready); end
      end
      out_ready = 1'b1;
      in_valid = 1'b1; codop = 4'd9; a = 16'h7FFF; b = 16'h0001;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_chk++; if (out !== 16'h8000) begin n_fail++; $display("FAIL b2b_out got %h want 8000", out); end
      n_chk++; if ({neg, zero, overflow, out_valid} !== 4'b1001) begin n_fail++; $display("FAIL b2b_flags_valid got %b want 1001", {neg, zero, overflow, out_valid}); end
      @(posedge clk);
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_mul;
      bit seen;
      do_issue(4'd14, 16'd300, 16'd300);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b1; codop = 4'd0; a = 16'h0005; b = 16'h0005;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmul%0d_out_valid got %b want 0", i, out_valid); end
      end
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_chk++; if (out !== 16'h0000) begin n_fail++; $display("FAIL rstmul_out got %h want 0000", out); end
      n_chk++; if ({neg, zero, overflow} !== 3'b010) begin n_fail++; $display("FAIL rstmul_flags got %b want 010", {neg, zero, overflow}); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmul_out_valid got %b want 0", out_valid); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmul_in_ready got %b want 1", in_ready); end
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmul_stale_result got %b want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_vectors();
      test_mul(16'd300, 16'd300, 16'h5F90, 3'b001);
      test_mul(16'd7, 16'd6, 16'h002A, 3'b000);
      test_mul(16'hFFFF, 16'hFFFF, 16'h0001, 3'b001);
      test_mul(16'h0100, 16'h0100, 16'h0000, 3'b011);
      test_back_to_back();
      test_reset_mid_mul();
      test_mul(16'h0003, 16'hC000, 16'h4000, 3'b001);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
